// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the three register-file write requesters and the arbitrated
// register-file write port.
//   slave  : arbiter side (takes requests, drives ready and the write port)
//   master : requester / register-file side
// Signals:
//   iReqValid[2:0]         per-requester valid (0 ALU, 1 load, 2 CSR)
//   iReqAddr0/1/2          destination register per requester
//   iReqData0/1/2          write data per requester
//   oReqReady[2:0]         one-hot grant, combinational
//   oWriteEn               register-file write enable (registered)
//   oRdAddr, oWriteData    register-file write address / data (registered)
//   oGrantId               requester whose write is on the port
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [2:0]        iReqValid;
   logic [ADDR_W-1:0] iReqAddr0;
   logic [ADDR_W-1:0] iReqAddr1;
   logic [ADDR_W-1:0] iReqAddr2;
   logic [DATA_W-1:0] iReqData0;
   logic [DATA_W-1:0] iReqData1;
   logic [DATA_W-1:0] iReqData2;
   logic [2:0]        oReqReady;
   logic              oWriteEn;
   logic [ADDR_W-1:0] oRdAddr;
   logic [DATA_W-1:0] oWriteData;
   logic [1:0]        oGrantId;

   modport slave (
      input  iReqValid, iReqAddr0, iReqAddr1, iReqAddr2,
      input  iReqData0, iReqData1, iReqData2,
      output oReqReady, oWriteEn, oRdAddr, oWriteData, oGrantId
   );

   modport master (
      output iReqValid, iReqAddr0, iReqAddr1, iReqAddr2,
      output iReqData0, iReqData1, iReqData2,
      input  oReqReady, oWriteEn, oRdAddr, oWriteData, oGrantId
   );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Write-back arbiter: picks one of three register-file write requesters per
// cycle and presents the winner's write on a single registered write port.
// Ports:
//   iClk   clock, rising edge
//   iRstN  asynchronous active-low reset
//   iHold  freeze: no grants, pointer frozen, write port idles next edge
//   bus    wb_arbiter_if.slave (requests in, one-hot ready and write port out)
// Build option:
//   WB_ARB_FIXED_PRIO_EN  defined   -> fixed priority 0 > 1 > 2, no pointer
//                         undefined -> round-robin, priority rotates to the
//                                      requester after the last winner
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic         iClk,
   input  logic         iRstN,
   input  logic         iHold,
   wb_arbiter_if.slave  bus
);

   logic [2:0]        grant;
   logic              accept;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [1:0]        sel_id;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        id_q;

`ifndef WB_ARB_FIXED_PRIO_EN
   // Index (0..2) of the requester currently holding highest priority.
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
`endif

   // Grant selection. Ready is also gated by reset so nothing is accepted
   // while the block is held in reset.
   always_comb begin
      grant = '0;
      if (iRstN && !iHold) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         if      (bus.iReqValid[0]) grant = 3'b001;
         else if (bus.iReqValid[1]) grant = 3'b010;
         else if (bus.iReqValid[2]) grant = 3'b100;
`else
         case (ptr_q)
            2'd0: begin
               if      (bus.iReqValid[0]) grant = 3'b001;
               else if (bus.iReqValid[1]) grant = 3'b010;
               else if (bus.iReqValid[2]) grant = 3'b100;
            end
            2'd1: begin
               if      (bus.iReqValid[1]) grant = 3'b010;
               else if (bus.iReqValid[2]) grant = 3'b100;
               else if (bus.iReqValid[0]) grant = 3'b001;
            end
            2'd2: begin
               if      (bus.iReqValid[2]) grant = 3'b100;
               else if (bus.iReqValid[0]) grant = 3'b001;
               else if (bus.iReqValid[1]) grant = 3'b010;
            end
            default: grant = '0;
         endcase
`endif
      end
   end

   assign accept = |grant;

   // Winner's payload mux.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_id   = '0;
      unique case (grant)
         3'b001: begin
            sel_addr = bus.iReqAddr0;
            sel_data = bus.iReqData0;
            sel_id   = 2'd0;
         end
         3'b010: begin
            sel_addr = bus.iReqAddr1;
            sel_data = bus.iReqData1;
            sel_id   = 2'd1;
         end
         3'b100: begin
            sel_addr = bus.iReqAddr2;
            sel_data = bus.iReqData2;
            sel_id   = 2'd2;
         end
         default: begin
            sel_addr = '0;
            sel_data = '0;
            sel_id   = '0;
         end
      endcase
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   // Priority moves to the requester after the winner; idle cycles keep it.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (sel_id == 2'd2) ? 2'd0 : sel_id + 2'd1;
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Registered write port. A write to x0 is consumed but never enabled;
   // idle cycles drop the enable and keep the last address/data/id.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         id_q   <= '0;
      end else begin
         we_q <= accept && (sel_addr != '0);
         if (accept) begin
            addr_q <= sel_addr;
            data_q <= sel_data;
            id_q   <= sel_id;
         end
      end
   end

   assign bus.oReqReady  = grant;
   assign bus.oWriteEn   = we_q;
   assign bus.oRdAddr    = addr_q;
   assign bus.oWriteData = data_q;
   assign bus.oGrantId   = id_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a reference model: the model keeps the priority order as a list
// that is rotated after each grant, and a pending-request table per
// requester. Inputs change 1 time unit after the rising edge; outputs are
// checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic iClk = 1'b0;
   logic iRstN;
   logic iHold;

   wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .iClk  (iClk),
      .iRstN (iRstN),
      .iHold (iHold),
      .bus   (bus)
   );

   always #5 iClk = ~iClk;

   // Stimulus / model request table.
   logic [2:0]    mv;
   logic [AW-1:0] ma [3];
   logic [DW-1:0] md [3];
   bit            sticky;

   // Model of the write port and priority order.
   int            order[$];
   logic          exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   logic [1:0]    exp_id;
   bit            out_known;
   int            wait_c [3];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus.iReqValid = mv;
      bus.iReqAddr0 = ma[0];
      bus.iReqAddr1 = ma[1];
      bus.iReqAddr2 = ma[2];
      bus.iReqData0 = md[0];
      bus.iReqData1 = md[1];
      bus.iReqData2 = md[2];
   endtask

   task automatic model_reset();
      order     = {0, 1, 2};
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_id    = '0;
      out_known = 1'b1;
      for (int i = 0; i < 3; i++) wait_c[i] = 0;
   endtask

   // First requester in priority order with a pending request, or -1.
   function automatic int exp_grant();
      if (!iRstN || iHold) return -1;
      foreach (order[k]) begin
         if (mv[order[k]]) return order[k];
      end
      return -1;
   endfunction

   task automatic check_now(input int g);
      logic [2:0] er;
      er = (g < 0) ? 3'b000 : 3'(1 << g);
      chk("ready", 32'(bus.oReqReady), 32'(er));
      chk("write_en", 32'(bus.oWriteEn), 32'(exp_we));
      if (out_known) begin
         chk("rd_addr", 32'(bus.oRdAddr), 32'(exp_addr));
         chk("write_data", bus.oWriteData, exp_data);
         chk("grant_id", 32'(bus.oGrantId), 32'(exp_id));
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising
   // edge, then re-drive the inputs.
   task automatic cycle();
      int g;
      @(negedge iClk);
      g = exp_grant();
      check_now(g);
`ifndef WB_ARB_FIXED_PRIO_EN
      // Cycles a pending requester has waited with hold low before its grant.
      for (int i = 0; i < 3; i++) begin
         if (bus.oReqReady[i]) begin
            chk("starvation", 32'(wait_c[i] <= 2), 32'd1);
            wait_c[i] = 0;
         end else if (mv[i] && !iHold && iRstN) begin
            wait_c[i]++;
         end
      end
`endif
      @(posedge iClk);
      if (!iRstN) begin
         model_reset();
      end else if (g >= 0) begin
         exp_we = (ma[g] != '0);
         if (exp_we) begin
            exp_addr  = ma[g];
            exp_data  = md[g];
            exp_id    = 2'(g);
            out_known = 1'b1;
         end else begin
            out_known = 1'b0;
         end
`ifndef WB_ARB_FIXED_PRIO_EN
         while (order[0] != (g + 1) % 3) order.push_back(order.pop_front());
`endif
         if (!sticky) mv[g] = 1'b0;
      end else begin
         exp_we = 1'b0;
      end
      #1;
      apply();
   endtask

   initial begin
      iRstN  = 1'b0;
      iHold  = 1'b0;
      sticky = 1'b0;
      mv     = '0;
      for (int i = 0; i < 3; i++) begin
         ma[i] = '0;
         md[i] = '0;
      end
      apply();
      model_reset();

      // Reset state.
      repeat (2) cycle();
      iRstN = 1'b1;

      // All three requesters held valid: grants rotate 0,1,2,0,...
      sticky = 1'b1;
      mv     = 3'b111;
      ma[0] = 5'd1; ma[1] = 5'd2; ma[2] = 5'd3;
      md[0] = 32'hA; md[1] = 32'hB; md[2] = 32'hC;
      apply();
      repeat (6) cycle();
      sticky = 1'b0;
      mv     = '0;
      apply();
      repeat (2) cycle();

      // Write to x0 is consumed silently, then a real write to x5.
      mv[0] = 1'b1; ma[0] = 5'd0; md[0] = 32'hDEAD;
      apply();
      cycle();
      mv[0] = 1'b1; ma[0] = 5'd5; md[0] = 32'h1234;
      apply();
      repeat (2) cycle();

      // Park priority on requester 0, then hold for 4 cycles with 0 and 1 valid.
      mv = 3'b100; ma[2] = 5'd9; md[2] = 32'h99;
      apply();
      cycle();
      iHold = 1'b1;
      mv = 3'b011;
      ma[0] = 5'd10; md[0] = 32'h1010;
      ma[1] = 5'd11; md[1] = 32'h1111;
      apply();
      repeat (4) cycle();
      iHold = 1'b0;
      repeat (3) cycle();

      // Reset asserted after requester 1 is granted but before the edge.
      mv = 3'b010; ma[1] = 5'd7; md[1] = 32'h7777;
      apply();
      @(negedge iClk);
      check_now(exp_grant());
      iRstN = 1'b0;
      #1;
      model_reset();
      check_now(-1);
      mv = 3'b011; ma[0] = 5'd4; md[0] = 32'h4444;
      apply();
      repeat (2) cycle();
      iRstN = 1'b1;
      repeat (3) cycle();

      // Random traffic; a request stays stable until it is granted.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!mv[i] && $urandom_range(0, 2) != 0) begin
               mv[i] = 1'b1;
               ma[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
               md[i] = $urandom;
            end
         end
         iHold = ($urandom_range(0, 5) == 0);
         apply();
         cycle();
      end
      iHold = 1'b0;
      mv    = '0;
      apply();
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write-data width; SHALL match the register-file data width.
REQ-002 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 iClk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 iRstN  input  1  asynchronous, active-low reset.
REQ-005 iHold  input  1  freeze; no grants while high.
REQ-006 iReqValid  input  3  per-requester valid (bit0 ALU, bit1 load, bit2 CSR).
REQ-007 iReqAddr0/1/2  input  ADDR_W each  destination register per requester.
REQ-008 iReqData0/1/2  input  DATA_W each  write data per requester.
REQ-009 oReqReady  output  3  one-hot grant; a transfer SHALL occur when iReqValid[i] and oReqReady[i] are both high at a rising edge.
REQ-010 oWriteEn  output  1  register-file write enable.
REQ-011 oRdAddr  output  ADDR_W  register-file write address.
REQ-012 oWriteData  output  DATA_W  register-file write data.
REQ-013 oGrantId  output  2  index of the requester whose write is on the output this cycle (0-2).

Function
REQ-014 oReqReady SHALL be combinational from iReqValid, iHold and the priority pointer.
- At most one bit SHALL be set.
- oReqReady[i] SHALL be high only if iReqValid[i] is high and iHold is low.
REQ-015 Round-robin order: after a grant to requester i, the highest priority SHALL move to (i+1) mod 3. Cycles with no grant SHALL leave the pointer unchanged.
REQ-016 Latency: a request accepted at edge N SHALL drive oWriteEn, oRdAddr, oWriteData and oGrantId from edge N to edge N+1. This is one registered stage. The output SHALL hold for exactly one cycle.
REQ-017 A cycle with no accepted request SHALL give oWriteEn=0 at the next edge. oRdAddr, oWriteData and oGrantId SHALL then hold their last values.
REQ-018 An accepted request with address 0 SHALL be consumed (ready high, pointer advances). oWriteEn SHALL stay 0 for that slot.
REQ-019 iHold high SHALL:
- force oReqReady=0;
- drive oWriteEn=0 at the next edge;
- keep the pointer frozen.
A write already registered SHALL still complete.
REQ-020 Two requesters with the same address in one cycle SHALL be serialised in grant order. The later grant's data is written last.
REQ-021 A requester whose valid stays high SHALL be granted within 3 cycles in which iHold is low (no starvation).
REQ-022 A requester SHALL keep valid, address and data stable until its transfer completes. The block need not check this.

Reset
REQ-023 While iRstN is low:
- oWriteEn=0, oRdAddr=0, oWriteData=0, oGrantId=0;
- oReqReady=0;
- pointer = requester 0 highest.
REQ-024 Reset asserted mid-transfer SHALL discard the registered write without asserting oWriteEn. The first grant after deassertion SHALL come at the first rising edge.

Configuration
REQ-025 Macro WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 > 1 > 2. The pointer SHALL be removed and REQ-021 does not apply.
- Undefined: round-robin per REQ-015.
All other requirements SHALL hold in both builds.

Verification
REQ-026 Reset, then iReqValid=3'b111 held with addrs 1/2/3 and data A/B/C:
- grants SHALL be 0,1,2,0...;
- oWriteEn=1 every cycle from the second edge;
- oRdAddr sequence 1,2,3.
REQ-027 Request to x0, then x5: valid0 with addr 0 and data 0xDEAD, then valid0 with addr 5 and data 0x1234.
- First slot: oWriteEn=0 and the request is consumed.
- Next slot: oWriteEn=1, oRdAddr=5, oWriteData=0x1234.
REQ-028 iHold during requests: iHold=1 for 4 cycles with iReqValid=3'b011.
- oReqReady=0 and oWriteEn=0 throughout.
- After release, requester 0 SHALL be granted first (pointer unchanged).
REQ-029 Reset mid-transfer: grant requester 1 with addr 7, then pull iRstN low before the output edge.
- oWriteEn SHALL be 0 during reset and after it.
- The first post-reset grant SHALL go to requester 0.
REQ-030 Fixed-priority build: with WB_ARB_FIXED_PRIO_EN defined and iReqValid=3'b111 held for 3 cycles, requester 0 SHALL be granted all 3 cycles.
